// File: rtl/ir_alu.sv
// ir_alu: instruction register plus ALU and 32-entry register file slice.
// One register/immediate ALU or move operation per accepted instruction.
module ir_alu #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] sgpr_out,
    output logic [31:0]       ir_out
);

    localparam int PW = 2 * DATA_W;

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_OR      = 5'd5;
    localparam logic [4:0] OP_AND     = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_XNOR    = 5'd8;
    localparam logic [4:0] OP_NAND    = 5'd9;
    localparam logic [4:0] OP_NOR     = 5'd10;
    localparam logic [4:0] OP_NOT     = 5'd11;

    logic [31:0]       ir;
    logic [DATA_W-1:0] gpr [32];
    logic [DATA_W-1:0] sgpr;

    // Fields are decoded from the incoming word, not the held IR,
    // so the result belongs to the instruction being accepted.
    logic [4:0]        oper_type;
    logic [4:0]        rdst;
    logic [4:0]        rsrc1;
    logic              mode;
    logic [4:0]        rsrc2;
    logic [DATA_W-1:0] isrc;

    assign oper_type = instr[31:27];
    assign rdst      = instr[26:22];
    assign rsrc1     = instr[21:17];
    assign mode      = instr[16];
    assign rsrc2     = instr[15:11];
    assign isrc      = instr[DATA_W-1:0];

    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [PW-1:0]     prod;

    assign src1 = gpr[rsrc1];
    assign src2 = mode ? isrc : gpr[rsrc2];
    assign prod = {{DATA_W{1'b0}}, src1} * {{DATA_W{1'b0}}, src2};

    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] res_hi;
    logic              wr_gpr;
    logic              wr_sgpr;

    // Result select and write enables; opcodes 12..31 write nothing.
    always_comb begin
        res     = '0;
        res_hi  = '0;
        wr_gpr  = 1'b0;
        wr_sgpr = 1'b0;
        unique case (oper_type)
            OP_MOVSGPR: begin
                res    = sgpr;
                wr_gpr = 1'b1;
            end
            OP_MOV: begin
                res    = mode ? isrc : src1;
                wr_gpr = 1'b1;
            end
            OP_ADD: begin
                res    = src1 + src2;
                wr_gpr = 1'b1;
            end
            OP_SUB: begin
                res    = src1 - src2;
                wr_gpr = 1'b1;
            end
            OP_MUL: begin
                res     = prod[DATA_W-1:0];
                res_hi  = prod[PW-1:DATA_W];
                wr_gpr  = 1'b1;
                wr_sgpr = 1'b1;
            end
            OP_OR: begin
                res    = src1 | src2;
                wr_gpr = 1'b1;
            end
            OP_AND: begin
                res    = src1 & src2;
                wr_gpr = 1'b1;
            end
            OP_XOR: begin
                res    = src1 ^ src2;
                wr_gpr = 1'b1;
            end
            OP_XNOR: begin
                res    = ~(src1 ^ src2);
                wr_gpr = 1'b1;
            end
            OP_NAND: begin
                res    = ~(src1 & src2);
                wr_gpr = 1'b1;
            end
            OP_NOR: begin
                res    = ~(src1 | src2);
                wr_gpr = 1'b1;
            end
            OP_NOT: begin
                res    = ~(mode ? isrc : src1);
                wr_gpr = 1'b1;
            end
            default: begin
                res     = '0;
                wr_gpr  = 1'b0;
                wr_sgpr = 1'b0;
            end
        endcase
    end

    // IR load and register file / SGPR writeback on accepted instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir   <= '0;
            sgpr <= '0;
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else if (instr_valid) begin
            ir <= instr;
            if (wr_gpr) begin
                gpr[rdst] <= res;
            end
            if (wr_sgpr) begin
                sgpr <= res_hi;
            end
        end
    end

    assign dbg_data = gpr[dbg_addr];
    assign sgpr_out = sgpr;
    assign ir_out   = ir;

endmodule

// File: tb/tb_ir_alu.sv
// tb_ir_alu: directed-vector bench for ir_alu.
// Each task drives one scenario and checks against hand-computed values.
module tb_ir_alu;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [4:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] sgpr_out;
    logic [31:0] ir_out;

    int n_cmp = 0;
    int n_bad = 0;

    ir_alu #(.DATA_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .sgpr_out    (sgpr_out),
        .ir_out      (ir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [4:0] op,
                                          input logic [4:0] rd,
                                          input logic [4:0] rs1,
                                          input logic [15:0] imm);
        return {op, rd, rs1, 1'b1, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] op,
                                          input logic [4:0] rd,
                                          input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {op, rd, rs1, 1'b0, rs2, 11'b0};
    endfunction

    // Present one instruction for exactly one rising edge.
    task automatic exec(input logic [31:0] w);
        @(negedge clk);
        instr       = w;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic peek(input logic [4:0] a);
        dbg_addr = a;
        #1;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        #12;
        for (int a = 0; a < 32; a += 9) begin
            peek(5'(a));
            n_cmp++;
            if (dbg_data !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_gpr[%0d] got %h want 0000", a, dbg_data);
            end
        end
        n_cmp++;
        if (sgpr_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_sgpr got %h want 0000", sgpr_out);
        end
        n_cmp++;
        if (ir_out !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_ir got %h want 00000000", ir_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mov_imm_all;
        for (int a = 0; a < 32; a++) begin
            exec(enc_i(5'd1, 5'(a), 5'd0, 16'd2));
        end
        for (int a = 0; a < 32; a++) begin
            peek(5'(a));
            n_cmp++;
            if (dbg_data !== 16'd2) begin
                n_bad++;
                $display("FAIL mov_imm gpr[%0d] got %h want 0002", a, dbg_data);
            end
        end
        n_cmp++;
        if (sgpr_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL mov_imm_sgpr got %h want 0000", sgpr_out);
        end
    endtask

    task automatic test_add_imm;
        logic [31:0] w;
        w = enc_i(5'd2, 5'd0, 5'd2, 16'd4);
        exec(w);
        peek(5'd0);
        n_cmp++;
        if (dbg_data !== 16'd6) begin
            n_bad++;
            $display("FAIL add_imm got %h want 0006", dbg_data);
        end
        n_cmp++;
        if (ir_out !== w) begin
            n_bad++;
            $display("FAIL add_ir got %h want %h", ir_out, w);
        end
    endtask

    task automatic test_mov;
        exec(enc_r(5'd1, 5'd4, 5'd7, 5'd0));
        peek(5'd4);
        n_cmp++;
        if (dbg_data !== 16'd2) begin
            n_bad++;
            $display("FAIL mov_reg got %h want 0002", dbg_data);
        end
        exec(enc_i(5'd1, 5'd4, 5'd0, 16'd55));
        peek(5'd4);
        n_cmp++;
        if (dbg_data !== 16'd55) begin
            n_bad++;
            $display("FAIL mov_imm55 got %h want 0037", dbg_data);
        end
    endtask

    task automatic test_mul;
        exec(enc_i(5'd1, 5'd1, 5'd0, 16'h1234));
        exec(enc_i(5'd1, 5'd2, 5'd0, 16'h0100));
        exec(enc_r(5'd4, 5'd3, 5'd1, 5'd2));
        peek(5'd3);
        n_cmp++;
        if (dbg_data !== 16'h3400) begin
            n_bad++;
            $display("FAIL mul_lo got %h want 3400", dbg_data);
        end
        n_cmp++;
        if (sgpr_out !== 16'h0012) begin
            n_bad++;
            $display("FAIL mul_hi got %h want 0012", sgpr_out);
        end
        exec(enc_r(5'd0, 5'd5, 5'd0, 5'd0));
        peek(5'd5);
        n_cmp++;
        if (dbg_data !== 16'h0012) begin
            n_bad++;
            $display("FAIL movsgpr got %h want 0012", dbg_data);
        end
        // 0xFFFF * 0xFFFF = 0xFFFE0001 exercises the full upper half.
        exec(enc_i(5'd1, 5'd20, 5'd0, 16'hFFFF));
        exec(enc_i(5'd4, 5'd21, 5'd20, 16'hFFFF));
        peek(5'd21);
        n_cmp++;
        if (dbg_data !== 16'h0001 || sgpr_out !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL mul_max got %h:%h want FFFE:0001",
                     sgpr_out, dbg_data);
        end
    endtask

    task automatic test_wrap_logic;
        logic [15:0] exp_l [6];
        logic [4:0]  op_l  [6];
        logic [31:0] w;
        exec(enc_i(5'd1, 5'd1, 5'd0, 16'h0000));
        exec(enc_i(5'd3, 5'd6, 5'd1, 16'h0001));
        peek(5'd6);
        n_cmp++;
        if (dbg_data !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sub_wrap got %h want FFFF", dbg_data);
        end
        exec(enc_i(5'd2, 5'd7, 5'd6, 16'h0001));
        peek(5'd7);
        n_cmp++;
        if (dbg_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL add_wrap got %h want 0000", dbg_data);
        end
        exec(enc_i(5'd11, 5'd8, 5'd0, 16'h00FF));
        peek(5'd8);
        n_cmp++;
        if (dbg_data !== 16'hFF00) begin
            n_bad++;
            $display("FAIL not_imm got %h want FF00", dbg_data);
        end
        exec(enc_i(5'd1, 5'd9, 5'd0, 16'hF0F0));
        exec(enc_i(5'd1, 5'd10, 5'd0, 16'hFF00));
        op_l[0] = 5'd8;  exp_l[0] = 16'hF00F;
        op_l[1] = 5'd5;  exp_l[1] = 16'hFFF0;
        op_l[2] = 5'd6;  exp_l[2] = 16'hF000;
        op_l[3] = 5'd7;  exp_l[3] = 16'h0FF0;
        op_l[4] = 5'd9;  exp_l[4] = 16'h0FFF;
        op_l[5] = 5'd10; exp_l[5] = 16'h000F;
        for (int k = 0; k < 6; k++) begin
            exec(enc_r(op_l[k], 5'd11, 5'd9, 5'd10));
            peek(5'd11);
            n_cmp++;
            if (dbg_data !== exp_l[k]) begin
                n_bad++;
                $display("FAIL logic_op%0d got %h want %h",
                         op_l[k], dbg_data, exp_l[k]);
            end
        end
        exec(enc_r(5'd11, 5'd12, 5'd10, 5'd0));
        peek(5'd12);
        n_cmp++;
        if (dbg_data !== 16'h00FF) begin
            n_bad++;
            $display("FAIL not_reg got %h want 00FF", dbg_data);
        end
        // Immediate mode: rsrc2 bits (here 5'b11111) must be ignored.
        exec(enc_i(5'd2, 5'd9, 5'd9, 16'hF801));
        peek(5'd9);
        n_cmp++;
        if (dbg_data !== 16'hE8F1) begin
            n_bad++;
            $display("FAIL add_self got %h want E8F1", dbg_data);
        end
        w = enc_i(5'd15, 5'd11, 5'd9, 16'h1234);
        exec(w);
        peek(5'd11);
        n_cmp++;
        if (dbg_data !== 16'h000F) begin
            n_bad++;
            $display("FAIL undef_gpr got %h want 000F", dbg_data);
        end
        n_cmp++;
        if (ir_out !== w || sgpr_out !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL undef_ir got %h/%h want %h/FFFE",
                     ir_out, sgpr_out, w);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        instr       = enc_i(5'd1, 5'd13, 5'd0, 16'd5);
        instr_valid = 1'b1;
        @(negedge clk);
        instr       = enc_i(5'd2, 5'd13, 5'd13, 16'd3);
        @(negedge clk);
        instr_valid = 1'b0;
        peek(5'd13);
        n_cmp++;
        if (dbg_data !== 16'd8) begin
            n_bad++;
            $display("FAIL back_to_back got %h want 0008", dbg_data);
        end
    endtask

    task automatic test_idle;
        logic [31:0] ir_prev;
        ir_prev     = ir_out;
        instr       = enc_i(5'd1, 5'd13, 5'd0, 16'd99);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        peek(5'd13);
        n_cmp++;
        if (dbg_data !== 16'd8 || ir_out !== ir_prev) begin
            n_bad++;
            $display("FAIL idle got %h/%h want 0008/%h",
                     dbg_data, ir_out, ir_prev);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        instr       = enc_i(5'd1, 5'd14, 5'd0, 16'd77);
        instr_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        dbg_addr = 5'd13;
        #1;
        n_cmp++;
        if (dbg_data !== 16'h0 || sgpr_out !== 16'h0 || ir_out !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_async got %h/%h/%h want 0/0/0",
                     dbg_data, sgpr_out, ir_out);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        peek(5'd14);
        n_cmp++;
        if (dbg_data !== 16'h0 || ir_out !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_hold got %h/%h want 0/0", dbg_data, ir_out);
        end
        exec(enc_i(5'd1, 5'd14, 5'd0, 16'd1));
        peek(5'd14);
        n_cmp++;
        if (dbg_data !== 16'd1) begin
            n_bad++;
            $display("FAIL post_reset got %h want 0001", dbg_data);
        end
    endtask

    initial begin
        test_reset;
        test_mov_imm_all;
        test_add_imm;
        test_mov;
        test_mul;
        test_wrap_logic;
        test_back_to_back;
        test_idle;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
